// File: rtl/square_wave_gen.sv
// Square-wave generator: programmable high/low time in UNIT-cycle units, continuous or burst mode.
// Latency: the launch edge enters HIGH/LOW, so wave follows one cycle after en/start is sampled.
// Backpressure: none; settings are shadowed at each period start and live inputs never glitch a period.
module square_wave_gen #(
  parameter int W    = 4,
  parameter int UNIT = 10,
  parameter int BW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [W-1:0]  m,
  input  logic [W-1:0]  n,
  input  logic          start,
  input  logic [BW-1:0] burst_len,
  output logic          wave,
  output logic          period_tick,
  output logic          busy,
  output logic          done
);

  // Prescaler needs at least one bit even when UNIT == 1.
  localparam int PW = (UNIT > 1) ? $clog2(UNIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(UNIT - 1);
  localparam logic [W-1:0]  W_ONE   = W'(1);
  localparam logic [BW-1:0] B_ONE   = BW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [W-1:0]  m_sh_q, m_sh_d;
  logic [W-1:0]  n_sh_q, n_sh_d;
  logic          mode_sh_q, mode_sh_d;

  logic [W-1:0]  target;
  logic          unit_wrap;
  logic          phase_end;
  logic          period_end;
  logic          last_burst;
  logic          launch_req;
  logic          live_nonzero;

  // Phase/period boundary decode; depends only on registered state so outputs never follow inputs.
  always_comb begin
    target     = (state_q == S_HIGH) ? m_sh_q : n_sh_q;
    unit_wrap  = (pre_q == PRE_MAX);
    phase_end  = (state_q != S_IDLE) && unit_wrap && (cnt_q == (target - W_ONE));
    period_end = phase_end && ((state_q == S_LOW) || (n_sh_q == '0));
    last_burst = mode_sh_q && (burst_q == B_ONE);
  end

  // Output decode from registered state.
  always_comb begin
    wave        = (state_q == S_HIGH);
    busy        = (state_q != S_IDLE);
    period_tick = period_end;
    done        = period_end && last_burst;
  end

  // Next-state logic: launch, phase counting, period reload, burst countdown and enable abort.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    cnt_d        = cnt_q;
    burst_d      = burst_q;
    m_sh_d       = m_sh_q;
    n_sh_d       = n_sh_q;
    mode_sh_d    = mode_sh_q;
    live_nonzero = (m != '0) || (n != '0);
    launch_req   = live_nonzero && (!mode || (start && (burst_len != '0)));

    if (!en) begin
      // Abort: drop the running period silently and clear all counters.
      state_d = S_IDLE;
      pre_d   = '0;
      cnt_d   = '0;
      burst_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (launch_req) begin
            m_sh_d    = m;
            n_sh_d    = n;
            mode_sh_d = mode;
            burst_d   = burst_len;
            pre_d     = '0;
            cnt_d     = '0;
            state_d   = (m != '0) ? S_HIGH : S_LOW;
          end
        end
        S_HIGH, S_LOW: begin
          pre_d = unit_wrap ? '0 : (pre_q + 1'b1);
          if (unit_wrap) begin
            cnt_d = phase_end ? '0 : (cnt_q + W_ONE);
          end
          if (phase_end && !period_end) begin
            state_d = S_LOW;
          end else if (period_end) begin
            if (mode_sh_q) begin
              burst_d = burst_q - B_ONE;
            end
            if (last_burst) begin
              state_d = S_IDLE;
            end else begin
              // New period: resample the live settings at the boundary only.
              m_sh_d = m;
              n_sh_d = n;
              if (!live_nonzero) begin
                state_d = S_IDLE;
              end else begin
                state_d = (m != '0) ? S_HIGH : S_LOW;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
          burst_d = '0;
        end
      endcase
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      m_sh_q    <= '0;
      n_sh_q    <= '0;
      mode_sh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      m_sh_q    <= m_sh_d;
      n_sh_q    <= n_sh_d;
      mode_sh_q <= mode_sh_d;
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Bench for square_wave_gen: vector table of launch settings plus hand sequences for multi-cycle corners.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Summary line reports comparison and failure counts.
module tb_square_wave_gen;
  localparam int W    = 4;
  localparam int UNIT = 10;
  localparam int BW   = 8;
  localparam int WIN  = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic          start;
  logic [W-1:0]  m;
  logic [W-1:0]  n;
  logic [BW-1:0] burst_len;
  logic          wave;
  logic          period_tick;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          mode;
    logic          start;
    logic [W-1:0]  m;
    logic [W-1:0]  n;
    logic [BW-1:0] blen;
    int            exp_high;
    int            exp_ticks;
    int            exp_done;
    int            exp_busy_end;
  } vec_t;

  vec_t vecs[10];

  square_wave_gen #(.W(W), .UNIT(UNIT), .BW(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .m           (m),
    .n           (n),
    .start       (start),
    .burst_len   (burst_len),
    .wave        (wave),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    en        = 1'b0;
    mode      = 1'b0;
    start     = 1'b0;
    m         = '0;
    n         = '0;
    burst_len = '0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Launch with the vector's settings and compare a WIN-cycle window against a period-formula model.
  task automatic run_vector(input vec_t v, input int idx);
    int  hi, tk, dn, miss, busy_end, p, pos;
    bit  launched, active, ew, et, ed;
    hi = 0; tk = 0; dn = 0; miss = 0; busy_end = 0;
    apply_reset();
    mode      = v.mode;
    m         = v.m;
    n         = v.n;
    burst_len = v.blen;
    start     = v.start;
    en        = 1'b1;
    step();
    start = 1'b0;
    launched = ((v.m != 0) || (v.n != 0)) && (!v.mode || (v.start && (v.blen != 0)));
    p = (int'(v.m) + int'(v.n)) * UNIT;
    for (int j = 1; j <= WIN; j++) begin
      active = launched && (p > 0) && (!v.mode || (j <= int'(v.blen) * p));
      pos    = (p > 0) ? ((j - 1) % p) : 0;
      ew     = active && (pos < int'(v.m) * UNIT);
      et     = active && (pos == p - 1);
      ed     = et && v.mode && (j == int'(v.blen) * p);
      if (wave !== ew || period_tick !== et || done !== ed || busy !== active) miss++;
      hi += int'(wave);
      tk += int'(period_tick);
      dn += int'(done);
      if (j == WIN) busy_end = int'(busy);
      step();
    end
    chk($sformatf("v%0d_high_cycles", idx), hi, v.exp_high);
    chk($sformatf("v%0d_ticks", idx), tk, v.exp_ticks);
    chk($sformatf("v%0d_dones", idx), dn, v.exp_done);
    chk($sformatf("v%0d_busy_end", idx), busy_end, v.exp_busy_end);
    chk($sformatf("v%0d_cycle_mismatches", idx), miss, 0);
  endtask

  initial begin
    int  hi1, hi2, tk, dn, miss, done_at, busy60, busy61;
    bit  ew, et;

    //            mode  start  m     n     blen   high tick done busy_end
    vecs[0] = '{1'b0, 1'b0, 4'd3, 4'd2, 8'd0,  60, 2, 0, 1};
    vecs[1] = '{1'b0, 1'b0, 4'd0, 4'd2, 8'd0,   0, 5, 0, 1};
    vecs[2] = '{1'b0, 1'b0, 4'd2, 4'd0, 8'd0, 100, 5, 0, 1};
    vecs[3] = '{1'b0, 1'b0, 4'd0, 4'd0, 8'd0,   0, 0, 0, 0};
    vecs[4] = '{1'b0, 1'b0, 4'd4, 4'd1, 8'd0,  80, 2, 0, 1};
    vecs[5] = '{1'b1, 1'b1, 4'd1, 4'd1, 8'd3,  30, 3, 1, 0};
    vecs[6] = '{1'b1, 1'b1, 4'd1, 4'd1, 8'd0,   0, 0, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 4'd1, 4'd1, 8'd3,   0, 0, 0, 0};
    vecs[8] = '{1'b1, 1'b1, 4'd2, 4'd3, 8'd1,  20, 1, 1, 0};
    vecs[9] = '{1'b1, 1'b1, 4'd0, 4'd3, 8'd2,   0, 2, 1, 0};

    // Reset state, both while rst is held and just after release.
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; m = '0; n = '0; burst_len = '0;
    #3;
    chk("rst_hold_wave", int'(wave), 0);
    chk("rst_hold_busy", int'(busy), 0);
    chk("rst_hold_tick", int'(period_tick), 0);
    chk("rst_hold_done", int'(done), 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_rel_wave", int'(wave), 0);
    chk("rst_rel_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) run_vector(vecs[i], i);

    // Reprogram m mid-HIGH: current period stays 30/20, next period becomes 10/20.
    apply_reset();
    m = 4'd3; n = 4'd2; en = 1'b1;
    step();
    hi1 = 0; hi2 = 0; tk = 0; miss = 0;
    for (int j = 1; j <= 80; j++) begin
      ew = (j <= 30) || (j >= 51 && j <= 60);
      et = (j == 50) || (j == 80);
      if (wave !== ew || period_tick !== et) miss++;
      if (j <= 50) hi1 += int'(wave); else hi2 += int'(wave);
      tk += int'(period_tick);
      if (j == 15) m = 4'd1;
      step();
    end
    chk("reprog_high_first", hi1, 30);
    chk("reprog_high_second", hi2, 10);
    chk("reprog_ticks", tk, 2);
    chk("reprog_mismatches", miss, 0);

    // Second start pulse mid-burst is ignored.
    apply_reset();
    mode = 1'b1; m = 4'd1; n = 4'd1; burst_len = 8'd3; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    tk = 0; dn = 0; done_at = 0; busy60 = 0; busy61 = 0;
    for (int j = 1; j <= WIN; j++) begin
      tk += int'(period_tick);
      if (done === 1'b1) begin
        dn++;
        done_at = j;
      end
      if (j == 60) busy60 = int'(busy);
      if (j == 61) busy61 = int'(busy);
      start = (j == 25);
      step();
    end
    start = 1'b0;
    chk("burst_restart_ticks", tk, 3);
    chk("burst_restart_dones", dn, 1);
    chk("burst_done_cycle", done_at, 60);
    chk("burst_busy_last", busy60, 1);
    chk("burst_busy_after", busy61, 0);

    // Drop en during HIGH, then re-enable for a fresh full period.
    apply_reset();
    m = 4'd3; n = 4'd2; en = 1'b1;
    step();
    for (int j = 1; j <= 12; j++) step();
    chk("en_drop_pre_wave", int'(wave), 1);
    en = 1'b0;
    step();
    chk("en_drop_wave", int'(wave), 0);
    chk("en_drop_busy", int'(busy), 0);
    tk = 0;
    for (int j = 0; j < 8; j++) begin
      tk += int'(period_tick) + int'(wave) + int'(done);
      step();
    end
    chk("en_drop_quiet", tk, 0);
    en = 1'b1;
    step();
    miss = 0; hi1 = 0;
    for (int j = 1; j <= 50; j++) begin
      ew = (j <= 30);
      et = (j == 50);
      if (wave !== ew || period_tick !== et || busy !== 1'b1) miss++;
      hi1 += int'(wave);
      step();
    end
    chk("en_restart_high", hi1, 30);
    chk("en_restart_mismatches", miss, 0);

    // Asynchronous reset between edges, mid-HIGH.
    apply_reset();
    m = 4'd3; n = 4'd2; en = 1'b1;
    step();
    for (int j = 1; j < 5; j++) step();
    chk("arst_pre_wave", int'(wave), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wave", int'(wave), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(period_tick), 0);
    chk("arst_done", int'(done), 0);

    // Asynchronous reset landing on a tick cycle drops the pending tick.
    apply_reset();
    m = 4'd3; n = 4'd2; en = 1'b1;
    step();
    for (int j = 1; j < 50; j++) step();
    chk("arst_tick_pre", int'(period_tick), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tick_drop", int'(period_tick), 0);
    chk("arst_tick_busy", int'(busy), 0);
    m = 4'd1; n = 4'd1; mode = 1'b0; en = 1'b1;
    #3 rst = 1'b0;
    chk("arst_release_wave", int'(wave), 0);
    step();
    miss = 0;
    for (int j = 1; j <= 20; j++) begin
      ew = (j <= 10);
      et = (j == 20);
      if (wave !== ew || period_tick !== et) miss++;
      step();
    end
    chk("arst_restart_mismatches", miss, 0);

    // Mode is captured at launch only; flipping it mid-run keeps a continuous wave.
    apply_reset();
    m = 4'd1; n = 4'd1; burst_len = 8'd1; en = 1'b1;
    step();
    tk = 0; busy61 = 0;
    for (int j = 1; j <= WIN; j++) begin
      tk += int'(period_tick);
      if (j == WIN) busy61 = int'(busy);
      if (j == 5) mode = 1'b1;
      step();
    end
    chk("mode_live_ticks", tk, 5);
    chk("mode_live_busy", busy61, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
